// File: rtl/notgate_test_sequencer.sv
// Self-test sequencer for one inverter cell: drives A with alternating 0/1 vectors,
// waits a settle interval, samples Z and counts every vector where Z is not ~A.
//
// Ports:
//   clk, rst_n (sync, active-low), start  - clock, reset, run request (IDLE only)
//   dut_a / dut_z                         - cell input driven / cell output sampled
//   busy, done, pass, fail_cnt            - run status, end pulse, result, mismatches
//   first_fail_idx, first_fail_z          - first-mismatch log (NOTGATE_FAIL_LOG_EN)
//
// Optional feature macro: NOTGATE_FAIL_LOG_EN adds the first-mismatch log outputs.

module notgate_test_sequencer #(
    parameter int SETTLE_CYC = 2,
    parameter int N_PASSES   = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             dut_a,
    input  logic             dut_z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_cnt
`ifdef NOTGATE_FAIL_LOG_EN
    ,
    output logic [6:0]       first_fail_idx,
    output logic             first_fail_z
`endif
);

    // Counter is sized for SETTLE_CYC-1; a 1-bit counter is kept even when
    // SETTLE_CYC is 0 or 1 so the declaration is always legal.
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0] S_END =
        SW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [7:0] LAST = 8'(2 * N_PASSES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t           r_state;
    logic [7:0]       r_vec;
    logic [SW-1:0]    r_settle;
    logic             w_mis;
    logic [CNT_W-1:0] w_cnt_nxt;
`ifdef NOTGATE_FAIL_LOG_EN
    logic             r_logged;
`endif

    // Case inequality so a floating or unknown Z is a mismatch in simulation.
    assign w_mis     = (dut_z !== ~dut_a);
    assign w_cnt_nxt = (w_mis && (fail_cnt != '1))
                     ? fail_cnt + CNT_W'(1) : fail_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_vec    <= '0;
            r_settle <= '0;
            dut_a    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail_cnt <= '0;
`ifdef NOTGATE_FAIL_LOG_EN
            r_logged       <= 1'b0;
            first_fail_idx <= '0;
            first_fail_z   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= DRIVE;
                        busy     <= 1'b1;
                        fail_cnt <= '0;
                        pass     <= 1'b0;
                        r_vec    <= '0;
`ifdef NOTGATE_FAIL_LOG_EN
                        r_logged       <= 1'b0;
                        first_fail_idx <= '0;
                        first_fail_z   <= 1'b0;
`endif
                    end
                end
                DRIVE: begin
                    dut_a    <= r_vec[0];
                    r_settle <= '0;
                    r_state  <= (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
                end
                SETTLE: begin
                    if (r_settle == S_END) begin
                        r_state <= SAMPLE;
                    end else begin
                        r_settle <= r_settle + SW'(1);
                    end
                end
                SAMPLE: begin
                    fail_cnt <= w_cnt_nxt;
`ifdef NOTGATE_FAIL_LOG_EN
                    if (w_mis && !r_logged) begin
                        r_logged       <= 1'b1;
                        first_fail_idx <= r_vec[6:0];
                        first_fail_z   <= dut_z;
                    end
`endif
                    if (r_vec == LAST) begin
                        // Result is published together with the done pulse,
                        // so it already includes this final sample.
                        r_state <= DONE;
                        done    <= 1'b1;
                        pass    <= (w_cnt_nxt == '0);
                    end else begin
                        r_vec   <= r_vec + 8'd1;
                        r_state <= DRIVE;
                    end
                end
                DONE: begin
                    dut_a   <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
